// File: rtl/miter_sweep_sched_if.sv
// Handshake and data bundle for the equivalence-sweep scheduler.
// The controller side uses the master modport. The scheduler uses the slave modport.
// The optional per-partition mask port exists only when CMP_MASK_EN is defined.
interface miter_sweep_sched_if #(
    parameter int NPART = 8,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    localparam int IDX_W = (NPART > 1) ? $clog2(NPART) : 1;

    logic                   start;
    logic                   continuous;
    logic                   abort;
    logic                   clear;
    logic [NPART*WIDTH-1:0] gold_bus;
    logic [NPART*WIDTH-1:0] gate_bus;
`ifdef CMP_MASK_EN
    logic [NPART-1:0]       mask;
`endif
    logic                   busy;
    logic                   done;
    logic                   mismatch;
    logic [IDX_W-1:0]       first_idx;
    logic [WIDTH-1:0]       first_gold;
    logic [WIDTH-1:0]       first_gate;
    logic [CNT_W-1:0]       mismatch_cnt;
    logic [CNT_W-1:0]       sweep_cnt;

    modport master (
        output start, continuous, abort, clear, gold_bus, gate_bus,
`ifdef CMP_MASK_EN
        output mask,
`endif
        input  busy, done, mismatch, first_idx, first_gold, first_gate,
        input  mismatch_cnt, sweep_cnt
    );

    modport slave (
        input  start, continuous, abort, clear, gold_bus, gate_bus,
`ifdef CMP_MASK_EN
        input  mask,
`endif
        output busy, done, mismatch, first_idx, first_gold, first_gate,
        output mismatch_cnt, sweep_cnt
    );
endinterface

// File: rtl/miter_sweep_sched.sv
// Sequential equivalence-sweep scheduler. One WIDTH-bit comparator is
// time-shared across NPART gold/gate partition pairs. The scheduler scans
// one partition per cycle. It records a sticky mismatch, the first failing
// partition and its values, and saturating mismatch and sweep counts.
// Optional feature: define CMP_MASK_EN to add a per-partition compare mask.
module miter_sweep_sched #(
    parameter int NPART = 8,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    miter_sweep_sched_if.slave bus
);
    localparam int IDX_W = (NPART > 1) ? $clog2(NPART) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] gold_sel, gate_sel;
    logic             fail;
    logic             sweep_end;

    logic             mismatch_q;
    logic [IDX_W-1:0] first_idx_q;
    logic [WIDTH-1:0] first_gold_q, first_gate_q;
    logic [CNT_W-1:0] mismatch_cnt_q, sweep_cnt_q;

    // Select the partition pair currently under compare
    always_comb begin
        gold_sel = '0;
        gate_sel = '0;
        for (int unsigned i = 0; i < NPART; i++) begin
            if (idx == IDX_W'(i)) begin
                gold_sel = bus.gold_bus[i*WIDTH +: WIDTH];
                gate_sel = bus.gate_bus[i*WIDTH +: WIDTH];
            end
        end
        fail = (state == SCAN) && (gold_sel != gate_sel);
`ifdef CMP_MASK_EN
        if (bus.mask[idx]) fail = 1'b0;
`endif
        sweep_end = (state == REPORT) && !bus.abort;
    end

    // Next-state and next-index logic
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                idx_nxt = idx + IDX_W'(1);
                if (idx == IDX_W'(NPART - 1)) begin
                    state_nxt = REPORT;
                    idx_nxt   = '0;
                end
            end
            REPORT: begin
                idx_nxt   = '0;
                state_nxt = bus.continuous ? SCAN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
        if (bus.abort && state != IDLE) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end
    end

    // State register. busy/done are registered from the next state.
    // An abort that arrives while done is already high cannot retract it.
    // That abort still blocks the sweep count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            busy_q <= (state_nxt != IDLE);
            done_q <= (state_nxt == REPORT);
        end
    end

    // Result registers. Clear discards any same-cycle failure or sweep completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch_q     <= 1'b0;
            first_idx_q    <= '0;
            first_gold_q   <= '0;
            first_gate_q   <= '0;
            mismatch_cnt_q <= '0;
            sweep_cnt_q    <= '0;
        end else if (bus.clear) begin
            mismatch_q     <= 1'b0;
            first_idx_q    <= '0;
            first_gold_q   <= '0;
            first_gate_q   <= '0;
            mismatch_cnt_q <= '0;
            sweep_cnt_q    <= '0;
        end else begin
            if (fail) begin
                if (mismatch_cnt_q != '1) mismatch_cnt_q <= mismatch_cnt_q + CNT_W'(1);
                if (!mismatch_q) begin
                    mismatch_q   <= 1'b1;
                    first_idx_q  <= idx;
                    first_gold_q <= gold_sel;
                    first_gate_q <= gate_sel;
                end
            end
            if (sweep_end && sweep_cnt_q != '1) sweep_cnt_q <= sweep_cnt_q + CNT_W'(1);
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.mismatch     = mismatch_q;
    assign bus.first_idx    = first_idx_q;
    assign bus.first_gold   = first_gold_q;
    assign bus.first_gate   = first_gate_q;
    assign bus.mismatch_cnt = mismatch_cnt_q;
    assign bus.sweep_cnt    = sweep_cnt_q;
endmodule

// File: tb/tb_miter_sweep_sched.sv
// Directed self-checking bench for miter_sweep_sched (NPART=8, WIDTH=8).
// A second instance with CNT_W=4 exercises counter saturation.
// The mask case is included when CMP_MASK_EN is defined.
module tb_miter_sweep_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    miter_sweep_sched_if #(.NPART(8), .WIDTH(8), .CNT_W(16)) sif ();
    miter_sweep_sched_if #(.NPART(8), .WIDTH(8), .CNT_W(4))  sif4 ();

    miter_sweep_sched #(.NPART(8), .WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(sif)
    );
    miter_sweep_sched #(.NPART(8), .WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(sif4)
    );

    // Count one comparison and report it if it does not match
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Partition i carries i*0x11. Partition 3 has gold 0xA5.
    // d3 sets gate3 to 0x5A. d6 sets gate6 to 0x99 (gold6 is 0x66).
    task automatic set_buses(input bit d3, input bit d6);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] g;
            g = (i == 3) ? 8'hA5 : 8'(i * 8'h11);
            sif.gold_bus[i*8 +: 8] = g;
            sif.gate_bus[i*8 +: 8] = g;
        end
        if (d3) sif.gate_bus[3*8 +: 8] = 8'h5A;
        if (d6) sif.gate_bus[6*8 +: 8] = 8'h99;
    endtask

    // Pulse start and return the number of edges until done is seen (0 = timeout)
    task automatic run_sweep(output int lat);
        lat = 0;
        sif.start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            sif.start = 1'b0;
            if (sif.done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int d_cnt;
        int d_at [3];
        bit seen;

        sif.start = 0; sif.continuous = 0; sif.abort = 0; sif.clear = 0;
        sif4.start = 0; sif4.continuous = 0; sif4.abort = 0; sif4.clear = 0;
        sif4.gold_bus = '0;
        sif4.gate_bus = '1;
`ifdef CMP_MASK_EN
        sif.mask = '0;
        sif4.mask = '0;
`endif
        set_buses(0, 0);

        #1 rst = 1'b0;
        #2;
        check_val("rst_busy", 32'(sif.busy), 0);
        check_val("rst_done", 32'(sif.done), 0);
        check_val("rst_mismatch", 32'(sif.mismatch), 0);
        check_val("rst_first_idx", 32'(sif.first_idx), 0);
        check_val("rst_first_gold", 32'(sif.first_gold), 0);
        check_val("rst_first_gate", 32'(sif.first_gate), 0);
        check_val("rst_mismatch_cnt", 32'(sif.mismatch_cnt), 0);
        check_val("rst_sweep_cnt", 32'(sif.sweep_cnt), 0);
        tick(); tick();
        rst = 1'b1;

        // Idle with start low
        seen = 0;
        repeat (20) begin
            tick();
            if (sif.busy || sif.done) seen = 1;
        end
        check_val("idle_busy", 32'(seen), 0);

        // Equal buses
        run_sweep(lat);
        check_val("eq_latency", 32'(lat), 9);
        check_val("eq_mismatch", 32'(sif.mismatch), 0);
        check_val("eq_mismatch_cnt", 32'(sif.mismatch_cnt), 0);
        tick();
        check_val("eq_sweep_cnt", 32'(sif.sweep_cnt), 1);
        check_val("eq_busy_after", 32'(sif.busy), 0);

        // Partitions 3 and 6 differ
        set_buses(1, 1);
        run_sweep(lat);
        check_val("diff_latency", 32'(lat), 9);
        check_val("diff_mismatch", 32'(sif.mismatch), 1);
        check_val("diff_first_idx", 32'(sif.first_idx), 3);
        check_val("diff_first_gold", 32'(sif.first_gold), 32'hA5);
        check_val("diff_first_gate", 32'(sif.first_gate), 32'h5A);
        check_val("diff_mismatch_cnt", 32'(sif.mismatch_cnt), 2);
        tick();
        check_val("diff_sweep_cnt", 32'(sif.sweep_cnt), 2);

        // Clear while idle
        sif.clear = 1; tick(); sif.clear = 0;
        check_val("clr_mismatch", 32'(sif.mismatch), 0);
        check_val("clr_mismatch_cnt", 32'(sif.mismatch_cnt), 0);
        check_val("clr_sweep_cnt", 32'(sif.sweep_cnt), 0);
        check_val("clr_first_gold", 32'(sif.first_gold), 0);

        // Continuous mode, three sweeps
        sif.continuous = 1;
        sif.start = 1;
        d_cnt = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            sif.start = 0;
            if (sif.done) begin
                d_at[d_cnt] = n;
                d_cnt++;
                if (d_cnt == 3) begin
                    sif.continuous = 0;
                    break;
                end
            end
        end
        check_val("cont_done_count", 32'(d_cnt), 3);
        if (d_cnt == 3) begin
            check_val("cont_first_done", 32'(d_at[0]), 9);
            check_val("cont_gap1", 32'(d_at[1] - d_at[0]), 9);
            check_val("cont_gap2", 32'(d_at[2] - d_at[1]), 9);
        end
        check_val("cont_mismatch_cnt", 32'(sif.mismatch_cnt), 6);
        tick();
        check_val("cont_sweep_cnt", 32'(sif.sweep_cnt), 3);
        check_val("cont_busy_after", 32'(sif.busy), 0);

        // Clear in the cycle that compares partition 3
        sif.start = 1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            sif.start = 0;
        end
        sif.clear = 1; tick(); sif.clear = 0;
        check_val("clrfail_mismatch", 32'(sif.mismatch), 0);
        check_val("clrfail_mismatch_cnt", 32'(sif.mismatch_cnt), 0);
        check_val("clrfail_first_idx", 32'(sif.first_idx), 0);
        check_val("clrfail_sweep_cnt", 32'(sif.sweep_cnt), 0);
        seen = 0;
        for (int n = 1; n <= 20; n++) begin
            if (sif.done) begin
                seen = 1;
                break;
            end
            tick();
        end
        check_val("clrfail_done", 32'(seen), 1);
        check_val("clrfail_first_idx6", 32'(sif.first_idx), 6);
        check_val("clrfail_first_gold6", 32'(sif.first_gold), 32'h66);
        check_val("clrfail_first_gate6", 32'(sif.first_gate), 32'h99);
        check_val("clrfail_cnt1", 32'(sif.mismatch_cnt), 1);
        tick();
        check_val("clrfail_sweep1", 32'(sif.sweep_cnt), 1);

        // Abort during the cycle that compares partition 3
        sif.clear = 1; tick(); sif.clear = 0;
        sif.start = 1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            sif.start = 0;
        end
        sif.abort = 1; tick(); sif.abort = 0;
        check_val("abort_busy", 32'(sif.busy), 0);
        check_val("abort_done", 32'(sif.done), 0);
        check_val("abort_mismatch", 32'(sif.mismatch), 1);
        check_val("abort_first_idx", 32'(sif.first_idx), 3);
        check_val("abort_mismatch_cnt", 32'(sif.mismatch_cnt), 1);
        seen = 0;
        repeat (15) begin
            tick();
            if (sif.done || sif.busy) seen = 1;
        end
        check_val("abort_no_done", 32'(seen), 0);
        check_val("abort_sweep_cnt", 32'(sif.sweep_cnt), 0);

        // Asynchronous reset mid-sweep
        sif.start = 1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            sif.start = 0;
        end
        #3 rst = 1'b0;
        #1;
        check_val("areset_busy", 32'(sif.busy), 0);
        check_val("areset_mismatch", 32'(sif.mismatch), 0);
        check_val("areset_first_idx", 32'(sif.first_idx), 0);
        check_val("areset_mismatch_cnt", 32'(sif.mismatch_cnt), 0);
        #2 rst = 1'b1;
        tick();
        check_val("areset_idle", 32'(sif.busy), 0);

`ifdef CMP_MASK_EN
        // Masked partition 3 never fails
        set_buses(1, 0);
        sif.mask = 8'h08;
        run_sweep(lat);
        check_val("mask_latency", 32'(lat), 9);
        check_val("mask_mismatch", 32'(sif.mismatch), 0);
        check_val("mask_mismatch_cnt", 32'(sif.mismatch_cnt), 0);
        sif.mask = '0;
        tick();
`endif

        // CNT_W=4 saturation: all 8 partitions fail on every sweep
        sif4.continuous = 1;
        sif4.start = 1;
        d_cnt = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            sif4.start = 0;
            if (sif4.done) begin
                d_cnt++;
                if (d_cnt == 1) check_val("sat_cnt_sweep1", 32'(sif4.mismatch_cnt), 8);
                if (d_cnt == 3) begin
                    sif4.continuous = 0;
                    break;
                end
            end
        end
        check_val("sat_done_count", 32'(d_cnt), 3);
        check_val("sat_mismatch_cnt", 32'(sif4.mismatch_cnt), 15);
        check_val("sat_first_idx", 32'(sif4.first_idx), 0);
        tick();
        check_val("sat_sweep_cnt", 32'(sif4.sweep_cnt), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
